// File: rtl/burst_encoder_8_to_3.sv
// Sequential 8-to-3 encoder: latches a request vector and emits the index of each
// set bit, one per accepted output beat, in LSB-first or MSB-first priority order.
module burst_encoder_8_to_3 #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_vec,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_idx,
    output logic       out_last,
    output logic       busy,
    output logic       err_zero
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] pend;

    // Index of the highest-priority set bit; an all-zero vector yields 0.
    function automatic logic [2:0] pick_idx(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        if (LSB_FIRST) begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) r = i[2:0];
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) r = i[2:0];
            end
        end
        return r;
    endfunction

    function automatic logic single_bit(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    // Outputs come from state/pend only; enable gates just the two handshake flags.
    assign busy      = (state == EMIT);
    assign in_ready  = enable && (state == IDLE);
    assign out_valid = enable && (state == EMIT);
    assign out_idx   = pick_idx(pend);
    assign out_last  = single_bit(pend);

    // Handshake FSM: accept a vector in IDLE, retire one pending bit per output beat in EMIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend     <= 8'd0;
            err_zero <= 1'b0;
        end else begin
            err_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && enable) begin
                        if (in_vec != 8'd0) begin
                            pend  <= in_vec;
                            state <= EMIT;
                        end else begin
                            err_zero <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (enable && out_ready) begin
                        pend <= pend & ~(8'd1 << out_idx);
                        if (out_last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    pend  <= 8'd0;
                end
            endcase
        end
    end

endmodule
